debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Multi-channel, parametrised debouncer for board buttons and switches.
- Each channel is synchronised, polarity-normalised and filtered by its own stability counter, then reported as a debounced level.
- Each channel also reports one-cycle press/release pulses and a long-press level.
- Sits between raw FPGA pins and the board control/debug logic, replacing the single-channel debouncer.

Parameters:
- channels_p, 4, number of independent input channels (>=1).
- stable_cycles_p, 1024, consecutive cycles the synchronised input must hold before the debounced state follows (>=1).
- long_cycles_p, 0, cycles the debounced level must stay 1 before long_o asserts; 0 disables long-press (long_o tied 0).
- invert_mask_p, 0, per-channel bit; 1 means the pin is active-low and is inverted before synchronisation.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- raw_i  in  channels_p  raw asynchronous pin levels.
- db_o  out  channels_p  debounced, active-high levels.
- rise_o  out  channels_p  one-cycle pulse when db_o goes 0->1.
- fall_o  out  channels_p  one-cycle pulse when db_o goes 1->0.
- long_o  out  channels_p  level; 1 while the channel has been held >= long_cycles_p cycles.

Behaviour:
- Reset: all flops clear asynchronously to 0, including s1, s2, cnt, db, rise, fall, hold and long. Outputs stay 0 until a qualified change.
- Reset mid-operation: a pending qualification is discarded, with no pulse on exit.
- Per channel, n = raw_i ^ invert_mask_p. Idle active-low pins therefore normalise to 0 and cause no spurious rise after reset.
- Synchroniser: s1 <= n, s2 <= s1.
- Clear condition: clr = s1 != s2.
- Counter: width clog2(stable_cycles_p+1).
  - clr: cnt <= 0.
  - else if cnt < stable_cycles_p: cnt <= cnt+1.
  - else: cnt holds (saturates, no wrap).
- State update: when cnt == stable_cycles_p and s2 != db, then db <= s2.
- Pulses: in that same edge, rise <= s2 and fall <= ~s2; otherwise rise, fall <= 0. Pulses are registered and coincide exactly with the first cycle of the new db_o value.
- Latency: raw step at edge 0 (first sampling edge) with no further change → db_o changes after edge stable_cycles_p+2 (the edge that sees cnt == stable_cycles_p).
  - Any toggle of s1 before then restarts the count.
  - A glitch shorter than one clock that s1 does not capture is ignored.
- Glitch returning to the old level: the count restarts and db stays unchanged, with no pulse.
- Long press (long_cycles_p > 0): hold counter of width clog2(long_cycles_p+1).
  - Resets to 0 while db == 0.
  - Increments while db == 1, saturating at long_cycles_p.
  - long <= (db == 1) && (hold == long_cycles_p). long_o therefore rises long_cycles_p+1 cycles after db_o rises.
  - long_o drops in the same cycle db_o falls: the combinational qualifier uses the next db value.
- Channel independence: channels share nothing but clock and reset. Simultaneous events on different channels are independent and all are reported in the same cycle.
- Outputs are all registered; there is no combinational path from raw_i to any output.

Decomposition:
- Shared package debounce_pkg: function for counter width (safe clog2 of N+1), and a struct per channel {db, rise, fall, long} used by consumers that pack status into CSRs.
- Sub-module debounce_chan:
  - One channel: synchroniser, stability counter, pulse generator, hold counter.
  - Parameters stable_cycles_p, long_cycles_p, invert_p.
- debounce_multi is a generate loop of channels_p instances plus mask slicing.

Test Plan (channels_p=4, stable_cycles_p=8, long_cycles_p=20, invert_mask_p=4'b1000):
- Clean step: raw_i[0] 0->1, held → db_o[0] rises after edge 10, rise_o[0] high exactly 1 cycle that cycle, fall_o[0] stays 0, other channels unaffected.
- Bounce: raw_i[1] toggles every 5 cycles for 40 cycles, then settles at 1 → db_o[1] stays 0 throughout the bounce and rises 10 edges after the last toggle, with a single rise pulse.
- Long press: hold raw_i[0]=1 → long_o[0] rises 21 cycles after db_o[0]. Release → fall_o[0] pulses, and long_o[0] and db_o[0] drop together 10 edges after release.
- Active-low idle: raw_i[3]=1 from reset → db_o[3]=0 with no pulses. Drive raw_i[3]=0 for 12 cycles → db_o[3]=1, with a rise pulse.
- Async reset mid-qualification: assert reset_i at cnt=5 with no clock edge → all outputs 0 immediately. After release with input still 1 → full 10-edge requalification, then rise.
- Simultaneous: steps on channels 0 and 2 at the same edge → both db_o bits and both rise_o bits assert in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
`timescale 1ns/1ps
package debounce_pkg;

  // Width of a counter that must hold values 0..n. Never returns less than 1 bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) < (n + 1))) w++;
    return w;
  endfunction

  // Per-channel status. Consumers pack this directly into CSR fields.
  typedef struct packed {
    logic db;
    logic rise;
    logic fall;
    logic long_press;
  } chan_status_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: polarity fix, 2-flop synchroniser, stability counter, edge pulses, long-press.
// Latency: a clean input step reaches db after stable_cycles_p+2 edges; long rises long_cycles_p+1 after db.
// Backpressure: none; the channel free-runs every cycle.
// Ports: clk_i/reset_i (async, active-high), raw_i (raw pin), status_o {db, rise, fall, long_press}.
`timescale 1ns/1ps
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   stable_cycles_p = 1024,
  parameter int   long_cycles_p   = 0,
  parameter logic invert_p        = 1'b0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         raw_i,
  output chan_status_t status_o
);

  localparam int                  cnt_w_lp   = cnt_width(stable_cycles_p);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(stable_cycles_p);

  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                db_q, db_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                long_q, long_d;

  always_comb begin
    // Inversion happens before the synchroniser so an idle active-low pin
    // reads as 0 right out of reset and never produces a spurious rise.
    s1_d   = raw_i ^ invert_p;
    s2_d   = s1_q;
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;

    // Any movement between the synchroniser stages restarts qualification.
    if (s1_q != s2_q) begin
      cnt_d = '0;
    end else if (cnt_q < cnt_max_lp) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Pulses are registered alongside db so they line up with its first new cycle.
    if ((cnt_q == cnt_max_lp) && (s2_q != db_q)) begin
      db_d   = s2_q;
      rise_d = s2_q;
      fall_d = ~s2_q;
    end
  end

  if (long_cycles_p > 0) begin : g_long
    localparam int                   hold_w_lp   = cnt_width(long_cycles_p);
    localparam logic [hold_w_lp-1:0] hold_max_lp = hold_w_lp'(long_cycles_p);

    logic [hold_w_lp-1:0] hold_q, hold_d;

    always_comb begin
      hold_d = hold_q;
      if (!db_q) begin
        hold_d = '0;
      end else if (hold_q < hold_max_lp) begin
        hold_d = hold_q + 1'b1;
      end
      // Qualify with the next db value so long drops on the same edge db falls.
      long_d = db_d && (hold_q == hold_max_lp);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_d;
      end
    end
  end else begin : g_no_long
    assign long_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      long_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      long_q <= long_d;
    end
  end

  assign status_o.db         = db_q;
  assign status_o.rise       = rise_q;
  assign status_o.fall       = fall_q;
  assign status_o.long_press = long_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: channels_p independent debounce_chan instances sharing only clock and reset.
// Latency: stable_cycles_p+2 edges from a clean pin step to db_o; all outputs registered.
// Backpressure: none; every channel free-runs.
// Ports: clk_i, reset_i (async, active-high), raw_i (pins), db_o (levels), rise_o/fall_o (1-cycle pulses), long_o (long-press level).
`timescale 1ns/1ps
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int                    channels_p      = 4,
  parameter int                    stable_cycles_p = 1024,
  parameter int                    long_cycles_p   = 0,
  parameter logic [channels_p-1:0] invert_mask_p   = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [channels_p-1:0] raw_i,
  output logic [channels_p-1:0] db_o,
  output logic [channels_p-1:0] rise_o,
  output logic [channels_p-1:0] fall_o,
  output logic [channels_p-1:0] long_o
);

  for (genvar i = 0; i < channels_p; i++) begin : g_chan
    chan_status_t status;

    debounce_chan #(
      .stable_cycles_p(stable_cycles_p),
      .long_cycles_p  (long_cycles_p),
      .invert_p       (invert_mask_p[i])
    ) u_chan (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .raw_i   (raw_i[i]),
      .status_o(status)
    );

    assign db_o[i]   = status.db;
    assign rise_o[i] = status.rise;
    assign fall_o[i] = status.fall;
    assign long_o[i] = status.long_press;
  end

endmodule

// File: tb/tb_debounce_multi.sv
`timescale 1ns/1ps
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] raw_i;
  logic [3:0] db_o, rise_o, fall_o, long_o;

  debounce_multi #(
    .channels_p     (4),
    .stable_cycles_p(8),
    .long_cycles_p  (20),
    .invert_mask_p  (4'b1000)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .raw_i  (raw_i),
    .db_o   (db_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .long_o (long_o)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         at_edge;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] lng;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic expect_ev(input int at, input logic [3:0] db, input logic [3:0] rise,
                           input logic [3:0] fall, input logic [3:0] lng);
    ev_t e;
    e.at_edge = at;
    e.db      = db;
    e.rise    = rise;
    e.fall    = fall;
    e.lng     = lng;
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse, or any change of db/long, is an output event to be matched.
  logic [3:0] p_db   = 4'b0;
  logic [3:0] p_long = 4'b0;
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        p_db   = db_o;
        p_long = long_o;
      end else if ((rise_o != 4'b0) || (fall_o != 4'b0) || (db_o != p_db) || (long_o != p_long)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event at edge %0d: db=%b rise=%b fall=%b long=%b, none required",
                   edge_n, db_o, rise_o, fall_o, long_o);
        end else begin
          e = exp_q.pop_front();
          chk_int("event_edge", edge_n, e.at_edge);
          chk4("event_db", db_o, e.db);
          chk4("event_rise", rise_o, e.rise);
          chk4("event_fall", fall_o, e.fall);
          chk4("event_long", long_o, e.lng);
        end
        p_db   = db_o;
        p_long = long_o;
      end
    end
  end

  initial begin
    int d;
    reset_i = 1'b1;
    raw_i   = 4'b1000;          // channel 3 is active-low and idle high

    // Reset state.
    @(negedge clk);
    chk4("reset_db", db_o, 4'b0);
    chk4("reset_rise", rise_o, 4'b0);
    chk4("reset_fall", fall_o, 4'b0);
    chk4("reset_long", long_o, 4'b0);
    wait_neg(2);
    #2 reset_i = 1'b0;
    wait_neg(12);

    // Clean step on ch0, long press, then release.
    raw_i = 4'b1001;
    d = edge_n;
    expect_ev(d + 11, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    expect_ev(d + 32, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_neg(40);
    raw_i = 4'b1000;
    d = edge_n;
    expect_ev(d + 11, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    wait_neg(15);

    // Bounce on ch1: toggles every 5 cycles for 40 cycles, then settles high.
    raw_i = 4'b1010;
    for (int i = 0; i < 7; i++) begin
      wait_neg(5);
      raw_i[1] = ~raw_i[1];
    end
    wait_neg(5);
    raw_i[1] = 1'b1;
    d = edge_n;
    expect_ev(d + 11, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    expect_ev(d + 32, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    wait_neg(35);

    // Active-low ch3 pressed (driven low) for 12 cycles.
    raw_i = 4'b0010;
    d = edge_n;
    expect_ev(d + 11, 4'b1010, 4'b1000, 4'b0000, 4'b0010);
    wait_neg(12);
    raw_i = 4'b1010;
    d = edge_n;
    expect_ev(d + 11, 4'b0010, 4'b0000, 4'b1000, 4'b0010);
    wait_neg(15);

    // Simultaneous steps on ch0 and ch2.
    raw_i = 4'b1111;
    d = edge_n;
    expect_ev(d + 11, 4'b0111, 4'b0101, 4'b0000, 4'b0010);
    expect_ev(d + 32, 4'b0111, 4'b0000, 4'b0000, 4'b0111);
    wait_neg(35);
    raw_i = 4'b1010;
    d = edge_n;
    expect_ev(d + 11, 4'b0010, 4'b0000, 4'b0101, 4'b0010);
    wait_neg(15);

    // Async reset while ch0/ch2 are mid-qualification (cnt == 5), ch1 held.
    raw_i = 4'b1111;
    wait_neg(7);
    #2 reset_i = 1'b1;
    #1;
    chk4("async_reset_db", db_o, 4'b0);
    chk4("async_reset_long", long_o, 4'b0);
    chk4("async_reset_rise", rise_o, 4'b0);
    chk4("async_reset_fall", fall_o, 4'b0);
    wait_neg(3);
    #2 reset_i = 1'b0;
    d = edge_n;
    expect_ev(d + 11, 4'b0111, 4'b0111, 4'b0000, 4'b0000);
    expect_ev(d + 32, 4'b0111, 4'b0000, 4'b0000, 4'b0111);
    wait_neg(40);

    chk_int("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
